// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM state enum
// and byte-lane helpers used by the top level and the lane aligner.
package mau_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } mau_state_e;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Bit offset of a byte lane inside a 32-bit little-endian word.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane handling: sub-word load extract/extend and
// read-modify-write merge of store data into the captured memory word.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel   = word_in[lane_shift(lane) +: BYTE_W];
    half_sel   = lane[1] ? word_in[31:16] : word_in[15:0];
    load_data  = word_in;
    merge_data = wdata;
    case (size)
      SIZE_B: begin
        load_data  = {{24{is_signed & byte_sel[BYTE_W-1]}}, byte_sel};
        merge_data = word_in;
        merge_data[lane_shift(lane) +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      SIZE_H: begin
        load_data  = {{16{is_signed & half_sel[HALF_W-1]}}, half_sel};
        merge_data = lane[1] ? {wdata[15:0], word_in[15:0]}
                             : {word_in[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = word_in;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a word-addressed data memory.
// Optional alignment checking is enabled by defining MAU_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request (cpu_ready = 1)
// RD    | mem_read_memory held for RD_LAT cycles, word captured on the last
// WR    | single-cycle mem_write_memory strobe
// RSP   | one-cycle rsp_valid pulse
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_write_memory,
  output logic        mem_read_memory,
  input  logic [31:0] mem_readData
);

  localparam logic [1:0]  IDLE    = ST_IDLE;
  localparam logic [1:0]  RD      = ST_RD;
  localparam logic [1:0]  WR      = ST_WR;
  localparam logic [1:0]  RSP     = ST_RSP;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [2:0]  RD_LOAD = 3'(RD_LAT - 1);

  logic [1:0]  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        signed_q;
  logic        err_q;
  logic [2:0]  rd_cnt_q;

  logic        accept;
  logic        align_err;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

`ifdef MAU_ALIGN_CHECK_EN
  assign align_err = ((cpu_size == SIZE_H) && cpu_addr[0]) ||
                     ((cpu_size == SIZE_W) && (cpu_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign accept  = cpu_valid && (state_q == IDLE);
  assign req_err = ({2'b00, cpu_addr[31:2]} >= DEPTH_W) ||
                   (cpu_size == SIZE_X) || align_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= SIZE_B;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            size_q   <= cpu_size;
            we_q     <= cpu_we;
            signed_q <= cpu_signed;
            err_q    <= req_err;
            rd_cnt_q <= RD_LOAD;
            if (req_err)
              state_q <= RSP;
            else if (cpu_we && (cpu_size == SIZE_W))
              state_q <= WR;
            else
              state_q <= RD;
          end
        end
        RD: begin
          if (rd_cnt_q == '0) begin
            rdata_q <= mem_readData;
            state_q <= we_q ? WR : RSP;
          end else begin
            rd_cnt_q <= rd_cnt_q - 3'd1;
          end
        end
        WR:      state_q <= RSP;
        default: state_q <= IDLE;
      endcase
    end
  end

  mau_lane_align u_lane_align (
    .word_in    (rdata_q),
    .wdata      (wdata_q),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // All outputs decode from state so reset drives them to 0 (ready to 1).
  assign cpu_ready        = (state_q == IDLE);
  assign rsp_valid        = (state_q == RSP);
  assign rsp_err          = (state_q == RSP) && err_q;
  assign rsp_rdata        = ((state_q == RSP) && !we_q && !err_q) ? load_data : 32'h0;
  assign mem_read_memory  = (state_q == RD);
  assign mem_write_memory = (state_q == WR);
  assign mem_address      = ((state_q == RD) || (state_q == WR)) ?
                            {2'b00, addr_q[31:2]} : 32'h0;
  assign mem_writeData    = (state_q == WR) ? merge_data : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural data memory,
// a shadow reference memory and a queue of expected responses.
module tb_mem_access_unit;

  localparam int DEPTH  = 32;
  localparam int RD_LAT = 1;
`ifdef MAU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
    logic [3:0]  nrd;
    logic [3:0]  nwr;
  } exp_t;

  typedef struct packed {
    exp_t        rsp;
    logic        ready;
    logic        both;
    logic        after;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_write_memory;
  logic        mem_read_memory;
  logic [31:0] mem_readData;

  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];
  exp_t        exp_q  [$];
  int          n_vec = 0;
  int          n_miss = 0;

  mem_access_unit #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_size(cpu_size), .cpu_signed(cpu_signed), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_write_memory(mem_write_memory), .mem_read_memory(mem_read_memory),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  assign mem_readData = mem_read_memory ? mem[mem_address[4:0]] : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (mem_write_memory) mem[mem_address[4:0]] = mem_writeData;

  function automatic logic [31:0] model_load(logic [31:0] w, logic [31:0] a,
                                             logic [1:0] sz, logic sg);
    logic [31:0] s;
    case (sz)
      2'b00: begin
        s = (w >> (8 * a[1:0])) & 32'h0000_00FF;
        if (sg && s[7]) s = s | 32'hFFFF_FF00;
      end
      2'b01: begin
        s = (a[1] ? (w >> 16) : w) & 32'h0000_FFFF;
        if (sg && s[15]) s = s | 32'hFFFF_0000;
      end
      default: s = w;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] w, logic [31:0] a,
                                              logic [1:0] sz, logic [31:0] d);
    logic [31:0] m;
    int          sh;
    case (sz)
      2'b00: begin sh = 8 * a[1:0]; m = 32'h0000_00FF << sh; end
      2'b01: begin sh = a[1] ? 16 : 0; m = 32'h0000_FFFF << sh; end
      default: begin sh = 0; m = 32'hFFFF_FFFF; end
    endcase
    return (w & ~m) | ((d << sh) & m);
  endfunction

  function automatic logic model_err(logic [31:0] a, logic [1:0] sz);
    return (a[31:2] >= 30'(DEPTH)) || (sz == 2'b11) ||
           (ALIGN && (((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00))));
  endfunction

  function automatic exp_t model_rsp(logic we, logic [1:0] sz, logic sg, logic [31:0] a,
                                     logic [31:0] w);
    exp_t e;
    if (model_err(a, sz))          e = '{rdata: 32'h0, err: 1'b1, lat: 4'd1, nrd: 4'd0, nwr: 4'd0};
    else if (we && (sz == 2'b10)) e = '{rdata: 32'h0, err: 1'b0, lat: 4'd2, nrd: 4'd0, nwr: 4'd1};
    else if (we)                  e = '{rdata: 32'h0, err: 1'b0, lat: 4'(RD_LAT + 2),
                                        nrd: 4'(RD_LAT), nwr: 4'd1};
    else                          e = '{rdata: model_load(w, a, sz, sg), err: 1'b0,
                                        lat: 4'(RD_LAT + 1), nrd: 4'(RD_LAT), nwr: 4'd0};
    return e;
  endfunction

  // Drives one request from a negedge and watches the DUT until its response.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, output obs_t o);
    o = '0;
    cpu_valid = 1'b1; cpu_we = we; cpu_size = sz; cpu_signed = sg;
    cpu_addr = a; cpu_wdata = d;
    #1 o.ready = cpu_ready;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_read_memory) o.rsp.nrd = o.rsp.nrd + 4'd1;
      if (mem_write_memory) begin
        o.rsp.nwr = o.rsp.nwr + 4'd1;
        o.waddr = mem_address;
        o.wdata = mem_writeData;
      end
      if (mem_read_memory && mem_write_memory) o.both = 1'b1;
      if (rsp_valid) begin
        o.rsp.lat = 4'(c); o.rsp.rdata = rsp_rdata; o.rsp.err = rsp_err;
        break;
      end
    end
    @(negedge clk);
    o.after = rsp_valid || !cpu_ready;
  endtask

  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a[31:2] < 30'(DEPTH)) ? shadow[a[6:2]] : 32'h0;
  endfunction

  task automatic test_reset();
    #3;
    n_vec++;
    if ({cpu_ready, rsp_valid, rsp_err, rsp_rdata, mem_read_memory, mem_write_memory,
         mem_address, mem_writeData} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_miss++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h rd=%b wr=%b addr=%h wd=%h, want ready=1 and all others 0",
               cpu_ready, rsp_valid, rsp_err, rsp_rdata, mem_read_memory, mem_write_memory,
               mem_address, mem_writeData);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cpu_ready !== 1'b1) begin
      n_miss++; $display("FAIL reset_release_ready: got %b want 1", cpu_ready);
    end
  endtask

  task automatic test_word_store_load();
    obs_t o; exp_t e;
    exp_q.push_back(model_rsp(1'b1, 2'b10, 1'b0, 32'h08, word_of(32'h08)));
    run_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, o);
    shadow[2] = 32'hDEAD_BEEF;
    e = exp_q.pop_front();
    n_vec++;
    if (o.rsp !== e) begin
      n_miss++; $display("FAIL word_store_rsp: got %h want %h", o.rsp, e);
    end
    n_vec++;
    if ({o.waddr, o.wdata, mem[2]} !== {32'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
      n_miss++; $display("FAIL word_store_mem: got addr=%h data=%h mem2=%h want 2/deadbeef/deadbeef",
                         o.waddr, o.wdata, mem[2]);
    end
    exp_q.push_back(model_rsp(1'b0, 2'b10, 1'b0, 32'h08, word_of(32'h08)));
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, o);
    e = exp_q.pop_front();
    n_vec++;
    if (o.rsp !== e) begin
      n_miss++; $display("FAIL word_load_rsp: got %h want %h", o.rsp, e);
    end
  endtask

  task automatic test_byte_load();
    obs_t o; exp_t e;
    mem[1] = 32'h0000_8000; shadow[1] = 32'h0000_8000;
    for (int s = 1; s >= 0; s--) begin
      exp_q.push_back(model_rsp(1'b0, 2'b00, 1'(s), 32'h05, word_of(32'h05)));
      run_req(1'b0, 2'b00, 1'(s), 32'h05, 32'h0, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o.rsp !== e || o.rsp.rdata !== (s == 1 ? 32'hFFFF_FF80 : 32'h0000_0080)) begin
        n_miss++; $display("FAIL byte_load signed=%0d: got %h want %h", s, o.rsp, e);
      end
    end
  endtask

  task automatic test_half_rmw();
    obs_t o; exp_t e;
    mem[3] = 32'h1122_3344; shadow[3] = 32'h1122_3344;
    exp_q.push_back(model_rsp(1'b1, 2'b01, 1'b0, 32'h0E, word_of(32'h0E)));
    run_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_ABCD, o);
    shadow[3] = model_store(shadow[3], 32'h0E, 2'b01, 32'h0000_ABCD);
    e = exp_q.pop_front();
    n_vec++;
    if (o.rsp !== e || o.both !== 1'b0) begin
      n_miss++; $display("FAIL half_rmw_rsp: got %h both=%b want %h both=0", o.rsp, o.both, e);
    end
    n_vec++;
    if (mem[3] !== 32'hABCD_3344) begin
      n_miss++; $display("FAIL half_rmw_mem: got %h want abcd3344", mem[3]);
    end
    run_req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h1234_565A, o);
    n_vec++;
    if (mem[3] !== 32'hABCD_5A44) begin
      n_miss++; $display("FAIL byte_rmw_mem: got %h want abcd5a44", mem[3]);
    end
    shadow[3] = 32'hABCD_5A44;
  endtask

  task automatic test_errors();
    obs_t o; exp_t e;
    logic [31:0] a [3] = '{32'h80, 32'h00, 32'h84};
    logic [1:0]  z [3] = '{2'b10, 2'b11, 2'b00};
    logic        w [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 4'd1, nrd: 4'd0, nwr: 4'd0});
      run_req(w[i], z[i], 1'b0, a[i], 32'hFFFF_FFFF, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o.rsp !== e || o.after !== 1'b0) begin
        n_miss++; $display("FAIL error_req%0d: got %h after=%b want %h after=0", i, o.rsp, o.after, e);
      end
    end
  endtask

  task automatic test_align();
    obs_t o; exp_t e;
    mem[1] = 32'hCAFE_F00D; shadow[1] = 32'hCAFE_F00D;
    exp_q.push_back(model_rsp(1'b0, 2'b10, 1'b0, 32'h06, word_of(32'h06)));
    run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, o);
    e = exp_q.pop_front();
    n_vec++;
    if (o.rsp !== e) begin
      n_miss++; $display("FAIL align_word_load: got %h want %h", o.rsp, e);
    end
    exp_q.push_back(model_rsp(1'b0, 2'b01, 1'b1, 32'h07, word_of(32'h07)));
    run_req(1'b0, 2'b01, 1'b1, 32'h07, 32'h0, o);
    e = exp_q.pop_front();
    n_vec++;
    if (o.rsp !== e) begin
      n_miss++; $display("FAIL align_half_load: got %h want %h", o.rsp, e);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    mem[4] = 32'h5566_7788; shadow[4] = 32'h5566_7788;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h10; cpu_wdata = 32'hEE;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cpu_ready, mem_read_memory, mem_write_memory, mem_address} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_miss++; $display("FAIL reset_mid_outputs: got ready=%b rd=%b wr=%b addr=%h want 1/0/0/0",
                         cpu_ready, mem_read_memory, mem_write_memory, mem_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_write_memory || !cpu_ready) seen = 1'b1;
    end
    n_vec++;
    if ({seen, mem[4]} !== {1'b0, 32'h5566_7788}) begin
      n_miss++; $display("FAIL reset_mid_abort: got activity=%b mem4=%h want 0/55667788", seen, mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic        we, sg;
    for (int i = 0; i < 40; i++) begin
      a  = {25'd0, 5'($urandom_range(0, DEPTH + 3)), 2'($urandom_range(0, 3))};
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (i % 8 == 7) a = 32'h0000_0080 + 32'(i);
      exp_q.push_back(model_rsp(we, sz, sg, a, word_of(a)));
      run_req(we, sz, sg, a, d, o);
      if (we && !model_err(a, sz)) shadow[a[6:2]] = model_store(shadow[a[6:2]], a, sz, d);
      e = exp_q.pop_front();
      n_vec++;
      if (o.rsp !== e || {o.ready, o.both, o.after} !== 3'b100) begin
        n_miss++;
        $display("FAIL b2b[%0d] we=%b sz=%0d a=%h: got %h hs=%b want %h hs=100",
                 i, we, sz, a, o.rsp, {o.ready, o.both, o.after}, e);
      end
      if (we && a[31:2] < 30'(DEPTH)) begin
        n_vec++;
        if (mem[a[6:2]] !== shadow[a[6:2]]) begin
          n_miss++; $display("FAIL b2b_mem[%0d]: got %h want %h", i, mem[a[6:2]], shadow[a[6:2]]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      shadow[i] = mem[i];
    end
    test_reset();
    test_word_store_load();
    test_byte_load();
    test_half_rmw();
    test_errors();
    test_align();
    test_reset_mid();
    @(negedge clk);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 32, the number of 32-bit words in the attached data memory.
REQ-002 SHALL have parameter RD_LAT, default 1, the cycles mem_read_memory is held before mem_readData is sampled; legal range 1..7.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port cpu_valid, input, 1 bit: the CPU request is valid.
REQ-006 SHALL have port cpu_ready, output, 1 bit: the unit can accept a request.
REQ-007 SHALL have port cpu_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port cpu_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port cpu_signed, input, 1 bit: sign-extend sub-word loads.
REQ-010 SHALL have port cpu_addr, input, 32 bits: byte address.
REQ-011 SHALL have port cpu_wdata, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load result; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request was rejected; qualified by rsp_valid.
REQ-015 SHALL have memory-side ports: mem_address (out, 32, word index), mem_writeData (out, 32), mem_write_memory (out, 1), mem_read_memory (out, 1) and mem_readData (in, 32).

Function
REQ-016 SHALL have FSM states IDLE, RD, WR and RSP; cpu_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a posedge where cpu_valid && cpu_ready, and register addr, size, we, signed and wdata at that edge.
REQ-018 SHALL make the following transitions on accept:
- error: go to RSP.
- word store: go to WR.
- load or sub-word store: go to RD.
REQ-019 SHALL, in RD, drive mem_read_memory = 1 for exactly RD_LAT cycles and capture mem_readData on the last of them; then go to RSP for a load or to WR for a store.
REQ-020 SHALL, in WR, drive mem_write_memory = 1 for exactly one cycle, then go to RSP.
REQ-021 SHALL have a sub-word store perform read-modify-write: replace only the addressed lane of the captured word with cpu_wdata[7:0] or cpu_wdata[15:0].
REQ-022 SHALL use little-endian lanes: byte lane = addr[1:0]; half lane = addr[1].
REQ-023 SHALL extract sub-word load data from the selected lane; sign-extend it when signed = 1, else zero-extend it.
REQ-024 SHALL, in RSP, assert rsp_valid for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-025 SHALL drive mem_address = {2'b0, addr[31:2]} while in RD or WR; mem_address is 0 otherwise.
REQ-026 SHALL keep mem_read_memory and mem_write_memory 0 outside RD and WR respectively; they are never both 1.
REQ-027 SHALL define error as word index >= DEPTH, or size = 11 (plus misalignment per REQ-031); an errored request issues no memory strobes, rsp_err = 1, and rsp_rdata = 0.
REQ-028 SHALL define latency, with accept at edge 0:
- error: rsp_valid in cycle 1.
- word store: rsp_valid in cycle 2.
- load: rsp_valid in cycle RD_LAT+1.
- sub-word store: rsp_valid in cycle RD_LAT+2.

Reset
REQ-029 SHALL, on rst_n = 0 and asynchronously, force the state to IDLE and set every output to 0 except cpu_ready, which is 1 while rst_n = 0 is held.
REQ-030 SHALL, if reset occurs mid-operation, abort the operation: no partial write and no rsp_valid after release.

Configuration
REQ-031 SHALL, with MAU_ALIGN_CHECK_EN defined, flag as errors a half access with addr[0] = 1 and a word access with addr[1:0] != 0; without the macro, those address bits are ignored (the half lane uses addr[1] only, and a word access uses lane 0).

Structure
REQ-032 SHALL place the size encodings (SIZE_B, SIZE_H, SIZE_W), the FSM state enum and lane helper constants in package mau_pkg.
REQ-033 SHALL implement lane extract, extend and merge in combinational sub-module mau_lane_align.

Verification
REQ-034 SHALL cover a word store then load: store addr 0x08, data 0xDEADBEEF -> mem_write_memory pulses with mem_address = 2; the load from 0x08 returns 0xDEADBEEF in cycle 2 (RD_LAT = 1).
REQ-035 SHALL cover a signed byte load: memory word 1 = 0x00008000, load byte at 0x05, signed -> rsp_rdata = 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 SHALL cover a half store read-modify-write: word 3 = 0x11223344, store half 0xABCD at 0x0E -> word 3 = 0xABCD3344, with one read then one write strobe, and rsp_valid in cycle 3.
REQ-037 SHALL cover out-of-range and illegal-size requests: load at 0x80 (index 32) -> rsp_valid with rsp_err = 1 in cycle 1, and no memory strobes; size = 11 gives the same result.
REQ-038 SHALL cover MAU_ALIGN_CHECK_EN: word load at 0x06 -> rsp_err = 1 when defined; when undefined it returns word 1.
REQ-039 SHALL cover reset mid-operation: assert rst_n = 0 during the RD of a byte store -> word unchanged, no rsp_valid, and cpu_ready = 1 after release.
